// File: rtl/posit_decode_arbiter_pkg.sv
// Shared posit types and helpers for the decode arbiter slice.
package posit_types;

  typedef enum logic {
    SIGN_POS = 1'b0,
    SIGN_NEG = 1'b1
  } sign_t;

  // Tag width for n requesters; never returns less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/posit_decode_arbiter_if.sv
// Requester and result bus of posit_decode_arbiter. out_zero/out_nar exist
// only when POSIT_DECODE_SPECIAL_EN is defined.
interface posit_decode_arbiter_if
  import posit_types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int width   = 32
);
  localparam int ID_W = clog2_min1(NUM_REQ);

  // A transfer happens on a rising clk edge where valid && ready; the source
  // holds nothing stable for us (req_valid may drop unaccepted), the sink
  // holds out_* stable while out_valid && !out_ready.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*width-1:0] req_p;
  logic                     out_valid;
  logic                     out_ready;
  logic [ID_W-1:0]          out_id;
  sign_t                    out_sign;
  logic signed [width-2:0]  out_regime;
  logic signed [width-2:0]  out_exp;
  logic [width-2:0]         out_frac;
`ifdef POSIT_DECODE_SPECIAL_EN
  logic                     out_zero;
  logic                     out_nar;

  modport master (output req_valid, req_p, out_ready,
                  input  req_ready, out_valid, out_id, out_sign, out_regime,
                         out_exp, out_frac, out_zero, out_nar);
  modport slave  (input  req_valid, req_p, out_ready,
                  output req_ready, out_valid, out_id, out_sign, out_regime,
                         out_exp, out_frac, out_zero, out_nar);
`else
  modport master (output req_valid, req_p, out_ready,
                  input  req_ready, out_valid, out_id, out_sign, out_regime,
                         out_exp, out_frac);
  modport slave  (input  req_valid, req_p, out_ready,
                  output req_ready, out_valid, out_id, out_sign, out_regime,
                         out_exp, out_frac);
`endif
endinterface

// File: rtl/posit_decode_arbiter_rr.sv
// Combinational round-robin picker: first asserted req at or after ptr.
module posit_rr_arbiter
  import posit_types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);
  logic [ID_W:0]   cand_full;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand_full = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_full = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand_full >= (ID_W+1)'(NUM_REQ)) cand_full = cand_full - (ID_W+1)'(NUM_REQ);
      cand = cand_full[ID_W-1:0];
      if (en && !grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/posit_variable_decode.sv
// Combinational posit field decoder: sign, regime k, es-bit exponent and
// left-aligned fraction (hidden bit not included).
module posit_variable_decode
  import posit_types::*;
#(
  parameter int width = 32,
  parameter int es    = 2
) (
  input  logic [width-1:0]        p,
  output sign_t                   sign,
  output logic signed [width-2:0] regime,
  output logic signed [width-2:0] exp,
  output logic [width-2:0]        frac
);
  localparam int W1 = width - 1;

  logic [width-1:0] mag;
  logic [W1-1:0]    body;
  logic [W1-1:0]    rem;
  logic [W1-1:0]    run;
  logic             run_done;

  always_comb begin
    sign     = sign_t'(p[width-1]);
    mag      = p[width-1] ? (~p + width'(1)) : p;
    body     = mag[W1-1:0];
    run      = '0;
    run_done = 1'b0;
    for (int i = W1 - 1; i >= 0; i--) begin
      if (!run_done && (body[i] == body[W1-1])) run = run + W1'(1);
      else                                      run_done = 1'b1;
    end
    regime = body[W1-1] ? $signed(run - W1'(1)) : -$signed(run);
    // Drop the regime run and its terminator; a full-length run leaves nothing.
    rem = body << (run + W1'(1));
    exp = '0;
    exp[es-1:0] = rem[W1-1 -: es];
    frac = rem << es;
  end
endmodule

// File: rtl/posit_decode_arbiter.sv
// Round-robin shared posit decoder with a 2-stage valid/ready pipeline.
// Optional zero/NaR flags: define POSIT_DECODE_SPECIAL_EN.
module posit_decode_arbiter
  import posit_types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int width   = 32,
  parameter int es      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  posit_decode_arbiter_if.slave         bus
);
  localparam int ID_W = clog2_min1(NUM_REQ);

  logic                    s1_valid;
  logic [width-1:0]        s1_p;
  logic [ID_W-1:0]         s1_id;
  logic [ID_W-1:0]         rr_ptr;
  logic [NUM_REQ-1:0]      gnt;
  logic [ID_W-1:0]         gnt_idx;
  logic                    gnt_any;
  logic                    s1_adv;
  logic                    s2_adv;
  sign_t                   dec_sign;
  logic signed [width-2:0] dec_regime;
  logic signed [width-2:0] dec_exp;
  logic [width-2:0]        dec_frac;
  logic                    special;

  assign s2_adv        = !bus.out_valid || bus.out_ready;
  assign s1_adv        = !s1_valid || s2_adv;
  assign bus.req_ready = gnt;

  posit_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .en        (s1_adv),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  posit_variable_decode #(.width(width), .es(es)) u_dec (
    .p      (s1_p),
    .sign   (dec_sign),
    .regime (dec_regime),
    .exp    (dec_exp),
    .frac   (dec_frac)
  );

`ifdef POSIT_DECODE_SPECIAL_EN
  localparam logic [width-1:0] NAR_P = {1'b1, {(width-1){1'b0}}};
  logic is_zero, is_nar;
  assign is_zero = (s1_p == '0);
  assign is_nar  = (s1_p == NAR_P);
  assign special = is_zero || is_nar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_zero <= 1'b0;
      bus.out_nar  <= 1'b0;
    end else if (s2_adv) begin
      bus.out_zero <= is_zero;
      bus.out_nar  <= is_nar;
    end
  end
`else
  assign special = 1'b0;
`endif

  // S1: granted operand register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (gnt_any) begin
      s1_valid <= 1'b1;
      s1_p     <= bus.req_p[gnt_idx*width +: width];
      s1_id    <= gnt_idx;
      rr_ptr   <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: decoded-field register driving the result bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_id     <= '0;
      bus.out_sign   <= SIGN_POS;
      bus.out_regime <= '0;
      bus.out_exp    <= '0;
      bus.out_frac   <= '0;
    end else if (s2_adv) begin
      bus.out_valid  <= s1_valid;
      bus.out_id     <= s1_id;
      bus.out_sign   <= dec_sign;
      bus.out_regime <= special ? '0 : dec_regime;
      bus.out_exp    <= special ? '0 : dec_exp;
      bus.out_frac   <= special ? '0 : dec_frac;
    end
  end
endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Bench for posit_decode_arbiter (NUM_REQ=4, width=32, es=2) with a queue
// based reference model of arbitration, occupancy and posit field decoding.
module tb_posit_decode_arbiter;
  import posit_types::*;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int ES      = 2;
  localparam int EXP_W   = 2 + 1 + 3*(WIDTH-1) + 2;

  logic clk;
  logic rst_n;

  posit_decode_arbiter_if #(.NUM_REQ(NUM_REQ), .width(WIDTH)) bus ();

  posit_decode_arbiter #(.NUM_REQ(NUM_REQ), .width(WIDTH), .es(ES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int cyc;
  int ptr_m;
  int dut_g;
  logic [WIDTH-1:0] pend_p [NUM_REQ];
  logic [EXP_W-1:0] exp_q [$];
  int               hs_q  [$];

  // ---------------- reference model ----------------
  function automatic logic [EXP_W-1:0] model(input logic [31:0] p, input int id);
    longint unsigned mag, body, remv;
    longint k, e, fr;
    int first, run, n, f;
    logic sgn, z, nr;
    logic [1:0] idb;
    sgn  = p[31];
    mag  = sgn ? ((64'h1_0000_0000 - {32'd0, p}) % 64'h1_0000_0000) : {32'd0, p};
    body = mag % (64'd1 << 31);
    first = int'((body >> 30) & 64'd1);
    run = 0;
    while (run < 31 && int'((body >> (30 - run)) & 64'd1) == first) run++;
    k = first ? run - 1 : -run;
    n = 30 - run;
    e = 0;
    fr = 0;
    if (n > 0) begin
      remv = body % (64'd1 << n);
      if (n >= ES) begin
        f  = n - ES;
        e  = longint'(remv >> f);
        fr = longint'((remv % (64'd1 << f)) << (31 - f));
      end else begin
        e = longint'(remv << (ES - n));
      end
    end
    z  = 1'b0;
    nr = 1'b0;
`ifdef POSIT_DECODE_SPECIAL_EN
    z  = (p == 32'h0);
    nr = (p == 32'h8000_0000);
    if (z || nr) begin
      k = 0; e = 0; fr = 0;
    end
`endif
    idb = id[1:0];
    return {idb, sgn, 31'(k), 31'(e), 31'(fr), z, nr};
  endfunction

  function automatic logic [WIDTH-1:0] rand_operand();
    logic [WIDTH-1:0] specials [6];
    specials = '{32'h0, 32'h8000_0000, 32'h7fff_ffff, 32'h0000_0001, 32'h4000_0000, 32'hc000_0000};
    if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  function automatic logic [EXP_W-1:0] actual();
    logic az, an;
    az = 1'b0;
    an = 1'b0;
`ifdef POSIT_DECODE_SPECIAL_EN
    az = bus.out_zero;
    an = bus.out_nar;
`endif
    return {bus.out_id, bus.out_sign, bus.out_regime, bus.out_exp, bus.out_frac, az, an};
  endfunction

  // ---------------- driver ----------------
  task automatic clear_model();
    exp_q.delete();
    hs_q.delete();
    ptr_m = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // One clock: drive at negedge, check just after, then advance the model to the next edge.
  task automatic step(input logic [3:0] rv, input logic ordy);
    int g, idx;
    logic [3:0] exp_rdy;
    logic exp_ov;
    logic [EXP_W-1:0] act;
    @(negedge clk);
    bus.req_valid = rv;
    bus.out_ready = ordy;
    bus.req_p = {pend_p[3], pend_p[2], pend_p[1], pend_p[0]};
    #1;
    cyc++;
    g = -1;
    exp_rdy = '0;
    if (exp_q.size() < 2 || ordy) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (ptr_m + k) % NUM_REQ;
        if (g < 0 && rv[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    dut_g = -1;
    for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k] === 1'b1) dut_g = k;
    vectors++;
    if (bus.req_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, exp_rdy);
    end
    exp_ov = 1'b0;
    if (exp_q.size() > 0) exp_ov = (cyc >= hs_q[0] + 2);
    vectors++;
    if (bus.out_valid !== exp_ov) begin
      miscompares++;
      $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, bus.out_valid, exp_ov);
    end
    if (exp_ov && bus.out_valid === 1'b1) begin
      act = actual();
      vectors++;
      if (act !== exp_q[0]) begin
        miscompares++;
        $display("FAIL result cyc=%0d got=%h want=%h", cyc, act, exp_q[0]);
      end
    end
    if (exp_ov && ordy) begin
      void'(exp_q.pop_front());
      void'(hs_q.pop_front());
    end
    if (g >= 0) begin
      exp_q.push_back(model(pend_p[g], g));
      hs_q.push_back(cyc);
      ptr_m = (g + 1) % NUM_REQ;
      pend_p[g] = rand_operand();
    end
  endtask

  task automatic check_grant(input string name, input int want);
    vectors++;
    if (dut_g !== want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, dut_g, want);
    end
  endtask

  task automatic drain();
    repeat (4) step(4'b0000, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    bus.req_p = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_valid got=%b/%b want=0/0000", bus.out_valid, bus.req_ready);
    end
    vectors++;
    if (actual() !== '0) begin
      miscompares++;
      $display("FAIL reset_fields got=%h want=0", actual());
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_single();
    pend_p[0] = 32'h4000_0000;
    step(4'b0001, 1'b1);
    check_grant("single_grant", 0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_sign !== SIGN_POS ||
        bus.out_regime !== '0 || bus.out_exp !== '0 || bus.out_frac !== '0) begin
      miscompares++;
      $display("FAIL single_result got=v%b id%0d s%0d r%0d e%0d f%h want=v1 id0 s0 r0 e0 f0",
               bus.out_valid, bus.out_id, bus.out_sign, bus.out_regime, bus.out_exp, bus.out_frac);
    end
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1);
      check_grant("rr_grant", i % NUM_REQ);
    end
    drain();
  endtask

  task automatic test_backpressure();
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0);
      check_grant("bp_no_grant", -1);
    end
    repeat (4) step(4'b1111, 1'b1);
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    step(4'b0100, 1'b1);
    check_grant("wrap_setup", 2);
    step(4'b1001, 1'b1);
    check_grant("wrap_g3a", 3);
    step(4'b1001, 1'b1);
    check_grant("wrap_g0", 0);
    step(4'b1001, 1'b1);
    check_grant("wrap_g3b", 3);
    drain();
  endtask

  task automatic test_special();
    pend_p[1] = 32'h8000_0000;
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
`ifdef POSIT_DECODE_SPECIAL_EN
    vectors++;
    if (bus.out_nar !== 1'b1 || bus.out_zero !== 1'b0 || bus.out_regime !== '0 ||
        bus.out_exp !== '0 || bus.out_frac !== '0) begin
      miscompares++;
      $display("FAIL special_nar got=nar%b zero%b r%0d e%0d f%h want=nar1 zero0 r0 e0 f0",
               bus.out_nar, bus.out_zero, bus.out_regime, bus.out_exp, bus.out_frac);
    end
`endif
    pend_p[2] = 32'h0;
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
`ifdef POSIT_DECODE_SPECIAL_EN
    vectors++;
    if (bus.out_zero !== 1'b1 || bus.out_nar !== 1'b0 || bus.out_regime !== '0 ||
        bus.out_exp !== '0 || bus.out_frac !== '0) begin
      miscompares++;
      $display("FAIL special_zero got=zero%b nar%b r%0d e%0d f%h want=zero1 nar0 r0 e0 f0",
               bus.out_zero, bus.out_nar, bus.out_regime, bus.out_exp, bus.out_frac);
    end
`endif
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    drain();
  endtask

  task automatic test_reset_midflight();
    logic [3:0] rv;
    int lowest;
    repeat (3) step(4'b1111, 1'b0);
    bus.req_valid = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_reset got=%b want=0", bus.out_valid);
    end
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv = 4'($urandom_range(1, 15));
    lowest = -1;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rv[k]) lowest = k;
    step(rv, 1'b1);
    check_grant("post_reset_grant", lowest);
    drain();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    dut_g = -1;
    for (int i = 0; i < NUM_REQ; i++) pend_p[i] = $urandom;
    clear_model();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_special();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
